// File: rtl/gcd_operand_fifo.sv
// Operand-pair FIFO feeding the GCD calculator: first-word fall-through, registered o_valid/o_ready, 1-cycle write-to-valid latency.
// Producer is stalled by o_ready when full; the head pair is held while i_ready=0. Optional o_level port under GCD_OPFIFO_LEVEL_EN.
module gcd_operand_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            i_a,
  input  logic [DW-1:0]            i_b,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [DW-1:0]            o_a,
  output logic [DW-1:0]            o_b,
  output logic                     o_valid,
  input  logic                     i_ready
`ifdef GCD_OPFIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   o_level
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [AW:0]     wr_ptr_next, rd_ptr_next;
  logic            wr_en, rd_en;
  logic            empty_next, full_next;

  assign wr_en = i_valid & o_ready;
  assign rd_en = o_valid & i_ready;

  assign wr_ptr_next = wr_ptr + {{AW{1'b0}}, wr_en};
  assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, rd_en};

  // The extra MSB distinguishes full (wrapped once) from empty.
  assign empty_next = (wr_ptr_next == rd_ptr_next);
  assign full_next  = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      o_valid <= !empty_next;
      o_ready <= !full_next;
    end
  end

  // Storage is never cleared; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr[AW-1:0]] <= {i_a, i_b};
    end
  end

  assign {o_a, o_b} = mem[rd_ptr[AW-1:0]];

`ifdef GCD_OPFIFO_LEVEL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_level <= '0;
    end else begin
      o_level <= wr_ptr_next - rd_ptr_next;
    end
  end
`endif

endmodule
